// File: rtl/ram_req_arbiter_if.sv
// Request/response bundle between the two masters and the RAM arbiter.
// Master n owns bit n of each 2-bit vector and slice n of the packed fields.
interface ram_req_arbiter_if #(
   parameter int WORD_WIDTH  = 4,
   parameter int INDEX_WIDTH = 4
);
   logic [1:0]               req_valid;
   logic [1:0]               req_ready;
   logic [1:0]               req_we;
   logic [2*INDEX_WIDTH-1:0] req_index;
   logic [2*WORD_WIDTH-1:0]  req_wdata;
   logic [1:0]               rsp_valid;
   logic [WORD_WIDTH-1:0]    rsp_data;
   logic                     rsp_err;

   modport master (
      output req_valid, req_we, req_index, req_wdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_index, req_wdata,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/ram_req_arbiter.sv
// Round-robin two-master front end for the on-chip RAM strobe/ack port.
// One transaction in flight; a missing ack turns into an error response.
module ram_req_arbiter #(
   parameter int WORD_WIDTH  = 4,
   parameter int INDEX_WIDTH = 4,
   parameter int TIMEOUT     = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   ram_req_arbiter_if.slave       bus_if,
   output logic                   ram_wr_o,
   input  logic                   ram_ack_wr_i,
   output logic [WORD_WIDTH-1:0]  ram_wr_data_o,
   output logic [INDEX_WIDTH-1:0] ram_wr_index_o,
   output logic                   ram_rd_o,
   input  logic                   ram_ack_rd_i,
   input  logic [WORD_WIDTH-1:0]  ram_rd_data_i,
   output logic [INDEX_WIDTH-1:0] ram_rd_index_o
);
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e                 state_q, state_d;
   logic                   last_q, last_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   we_q, we_d;
   logic                   id_q, id_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;
   logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
   logic [WORD_WIDTH-1:0]  data_q, data_d;
   logic                   err_q, err_d;

   logic gnt;
   logic accept;
   logic ack_hit;

   always_comb begin
      gnt = 1'b0;
      unique case (bus_if.req_valid)
         2'b01:   gnt = 1'b0;
         2'b10:   gnt = 1'b1;
         2'b11:   gnt = ~last_q;
         default: gnt = 1'b0;
      endcase
   end

   // Ready is suppressed during reset so nothing is offered before IDLE is known.
   assign bus_if.req_ready = (state_q == IDLE && !rst_i && |bus_if.req_valid)
                             ? (gnt ? 2'b10 : 2'b01) : 2'b00;
   assign accept  = |(bus_if.req_valid & bus_if.req_ready);
   assign ack_hit = we_q ? ram_ack_wr_i : ram_ack_rd_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         timer_q <= '0;
         we_q    <= 1'b0;
         id_q    <= 1'b0;
         index_q <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         timer_q <= timer_d;
         we_q    <= we_d;
         id_q    <= id_d;
         index_q <= index_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      timer_d = timer_q;
      we_d    = we_q;
      id_d    = id_q;
      index_d = index_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = bus_if.req_we[gnt];
               index_d = gnt ? bus_if.req_index[INDEX_WIDTH +: INDEX_WIDTH]
                             : bus_if.req_index[0 +: INDEX_WIDTH];
               wdata_d = gnt ? bus_if.req_wdata[WORD_WIDTH +: WORD_WIDTH]
                             : bus_if.req_wdata[0 +: WORD_WIDTH];
               id_d    = gnt;
               last_d  = gnt;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (ack_hit) begin
               data_d  = we_q ? '0 : ram_rd_data_i;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ram_wr_o       = (state_q == ISSUE) &  we_q;
   assign ram_rd_o       = (state_q == ISSUE) & ~we_q;
   assign ram_wr_index_o = index_q;
   assign ram_rd_index_o = index_q;
   assign ram_wr_data_o  = wdata_q;

   assign bus_if.rsp_valid = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
   assign bus_if.rsp_err   = (state_q == RESP) & err_q;
   assign bus_if.rsp_data  = data_q;
endmodule

// File: tb/tb_ram_req_arbiter.sv
// Directed bench for ram_req_arbiter with a one-cycle-ack RAM model.
// Inputs change at posedge+1 or negedge; outputs are sampled at negedge.
module tb_ram_req_arbiter;
   localparam int WW = 4;
   localparam int IW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ram_req_arbiter_if #(.WORD_WIDTH(WW), .INDEX_WIDTH(IW)) bus ();

   logic          ram_wr, ram_rd, ack_wr, ack_rd;
   logic [WW-1:0] ram_wdata, ram_rdata;
   logic [IW-1:0] wr_idx, rd_idx;

   logic          auto_en = 1'b1;
   logic          a_wr = 1'b0, a_rd = 1'b0;
   logic          m_wr = 1'b0, m_rd = 1'b0;
   logic [WW-1:0] a_data = '0, m_data = '0;
   logic [WW-1:0] mem [16];

   int n_chk  = 0;
   int n_fail = 0;

   assign ack_wr    = a_wr | m_wr;
   assign ack_rd    = a_rd | m_rd;
   assign ram_rdata = auto_en ? a_data : m_data;

   // RAM model: acks one cycle after the strobe when auto_en is set.
   always @(posedge clk) begin
      a_wr <= auto_en & ram_wr;
      a_rd <= auto_en & ram_rd;
      if (rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (ram_wr) begin
         mem[wr_idx] <= ram_wdata;
      end
      if (ram_rd) a_data <= mem[rd_idx];
   end

   ram_req_arbiter #(.WORD_WIDTH(WW), .INDEX_WIDTH(IW), .TIMEOUT(TO)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .bus_if         (bus),
      .ram_wr_o       (ram_wr),
      .ram_ack_wr_i   (ack_wr),
      .ram_wr_data_o  (ram_wdata),
      .ram_wr_index_o (wr_idx),
      .ram_rd_o       (ram_rd),
      .ram_ack_rd_i   (ack_rd),
      .ram_rd_data_i  (ram_rdata),
      .ram_rd_index_o (rd_idx)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.req_valid = 2'b11;
      bus.req_we    = 2'b00;
      bus.req_index = '0;
      bus.req_wdata = '0;
      rst = 1'b1;
      cyc(); cyc(); cyc();
      mid();
      n_chk++;
      if (bus.req_ready !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_ready: got %b want 00", bus.req_ready);
      end
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data, ram_wr, ram_rd,
           wr_idx, rd_idx, ram_wdata} !== '0) begin
         n_fail++;
         $display("FAIL rst_outs: got %b %b %h %b %b %h %h %h want all 0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_data, ram_wr, ram_rd,
                  wr_idx, rd_idx, ram_wdata);
      end
      cyc();
      rst = 1'b0;
      mid();
      n_chk++;
      if (bus.req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL first_grant: got %b want 01", bus.req_ready);
      end
      bus.req_valid = 2'b00;
      cyc();
   endtask

   task automatic test_write_read();
      bus.req_valid = 2'b01;
      bus.req_we    = 2'b01;
      bus.req_index = {4'h0, 4'h3};
      bus.req_wdata = {4'h0, 4'hA};
      mid();
      n_chk++;
      if (bus.req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL wr_ready: got %b want 01", bus.req_ready);
      end
      cyc();
      bus.req_valid = 2'b00;
      mid();
      n_chk++;
      if ({ram_wr, ram_rd, wr_idx, ram_wdata} !== {2'b10, 4'h3, 4'hA}) begin
         n_fail++;
         $display("FAIL wr_strobe: got wr=%b rd=%b idx=%h d=%h want 1 0 3 a",
                  ram_wr, ram_rd, wr_idx, ram_wdata);
      end
      cyc();
      mid();
      n_chk++;
      if ({bus.rsp_valid, ram_wr, ram_rd} !== 4'b0000) begin
         n_fail++;
         $display("FAIL wr_wait: got rsp=%b wr=%b rd=%b want 0",
                  bus.rsp_valid, ram_wr, ram_rd);
      end
      cyc();
      mid();
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_err} !== 3'b010) begin
         n_fail++;
         $display("FAIL wr_rsp: got v=%b e=%b want 01 0",
                  bus.rsp_valid, bus.rsp_err);
      end
      cyc();
      bus.req_valid = 2'b10;
      bus.req_we    = 2'b00;
      bus.req_index = {4'h3, 4'h0};
      mid();
      n_chk++;
      if (bus.req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL rd_ready: got %b want 10", bus.req_ready);
      end
      cyc();
      bus.req_valid = 2'b00;
      mid();
      n_chk++;
      if ({ram_wr, ram_rd, rd_idx} !== {2'b01, 4'h3}) begin
         n_fail++;
         $display("FAIL rd_strobe: got wr=%b rd=%b idx=%h want 0 1 3",
                  ram_wr, ram_rd, rd_idx);
      end
      cyc(); cyc();
      mid();
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b10, 1'b0, 4'hA}) begin
         n_fail++;
         $display("FAIL rd_rsp: got v=%b e=%b d=%h want 10 0 a",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      cyc();
   endtask

   task automatic test_round_robin();
      logic [1:0] exp;
      bus.req_valid = 2'b11;
      bus.req_we    = 2'b00;
      bus.req_index = {4'h2, 4'h1};
      for (int k = 0; k < 4; k++) begin
         exp = (k % 2 == 1) ? 2'b10 : 2'b01;
         mid();
         n_chk++;
         if (bus.req_ready !== exp) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got %b want %b", k, bus.req_ready, exp);
         end
         cyc();
         mid();
         n_chk++;
         if (bus.req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL rr_busy%0d: got %b want 00", k, bus.req_ready);
         end
         cyc(); cyc();
         mid();
         n_chk++;
         if (bus.rsp_valid !== exp) begin
            n_fail++;
            $display("FAIL rr_rsp%0d: got %b want %b", k, bus.rsp_valid, exp);
         end
         cyc();
      end
      bus.req_valid = 2'b00;
   endtask

   task automatic test_timeout();
      auto_en       = 1'b0;
      bus.req_valid = 2'b01;
      bus.req_we    = 2'b00;
      bus.req_index = {4'h0, 4'h5};
      mid();
      n_chk++;
      if (bus.req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL to_ready: got %b want 01", bus.req_ready);
      end
      cyc();
      bus.req_valid = 2'b00;
      repeat (8) cyc();
      mid();
      n_chk++;
      if (bus.rsp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL to_early: got %b want 00 at T+9", bus.rsp_valid);
      end
      cyc();
      mid();
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b01, 1'b1, 4'h0}) begin
         n_fail++;
         $display("FAIL to_rsp: got v=%b e=%b d=%h want 01 1 0",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      cyc();
      auto_en = 1'b1;
      mid();
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_err} !== 3'b000) begin
         n_fail++;
         $display("FAIL to_clear: got v=%b e=%b want 0 0",
                  bus.rsp_valid, bus.rsp_err);
      end
      cyc();
      bus.req_valid = 2'b10;
      bus.req_we    = 2'b10;
      bus.req_index = {4'h4, 4'h0};
      bus.req_wdata = {4'h6, 4'h0};
      mid();
      n_chk++;
      if (bus.req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL to_next_ready: got %b want 10", bus.req_ready);
      end
      cyc();
      bus.req_valid = 2'b00;
      cyc(); cyc();
      mid();
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_err} !== 3'b100) begin
         n_fail++;
         $display("FAIL to_next_rsp: got v=%b e=%b want 10 0",
                  bus.rsp_valid, bus.rsp_err);
      end
      cyc();
   endtask

   task automatic test_spurious_ack();
      auto_en       = 1'b0;
      bus.req_valid = 2'b01;
      bus.req_we    = 2'b00;
      bus.req_index = {4'h0, 4'h7};
      mid();
      n_chk++;
      if (bus.req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL sp_ready: got %b want 01", bus.req_ready);
      end
      cyc();
      bus.req_valid = 2'b00;
      mid();
      n_chk++;
      if ({ram_wr, ram_rd, rd_idx} !== {2'b01, 4'h7}) begin
         n_fail++;
         $display("FAIL sp_strobe: got wr=%b rd=%b idx=%h want 0 1 7",
                  ram_wr, ram_rd, rd_idx);
      end
      cyc();
      m_wr = 1'b1;
      cyc();
      m_wr = 1'b0;
      mid();
      n_chk++;
      if (bus.rsp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL sp_ignored: got %b want 00", bus.rsp_valid);
      end
      cyc();
      m_rd   = 1'b1;
      m_data = 4'h5;
      mid();
      n_chk++;
      if (bus.rsp_valid !== 2'b00) begin
         n_fail++;
         $display("FAIL sp_ack_cycle: got %b want 00", bus.rsp_valid);
      end
      cyc();
      m_rd = 1'b0;
      mid();
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {2'b01, 1'b0, 4'h5}) begin
         n_fail++;
         $display("FAIL sp_rsp: got v=%b e=%b d=%h want 01 0 5",
                  bus.rsp_valid, bus.rsp_err, bus.rsp_data);
      end
      cyc();
   endtask

   task automatic test_reset_mid();
      auto_en       = 1'b0;
      bus.req_valid = 2'b10;
      bus.req_we    = 2'b00;
      bus.req_index = {4'h9, 4'h2};
      mid();
      n_chk++;
      if (bus.req_ready !== 2'b10) begin
         n_fail++;
         $display("FAIL rm_ready: got %b want 10", bus.req_ready);
      end
      cyc();
      bus.req_valid = 2'b00;
      cyc();
      rst = 1'b1;
      cyc();
      rst           = 1'b0;
      m_rd          = 1'b1;
      m_data        = 4'h9;
      bus.req_valid = 2'b11;
      mid();
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_data} !== {2'b00, 4'h0}) begin
         n_fail++;
         $display("FAIL rm_no_rsp: got v=%b d=%h want 00 0",
                  bus.rsp_valid, bus.rsp_data);
      end
      n_chk++;
      if (bus.req_ready !== 2'b01) begin
         n_fail++;
         $display("FAIL rm_grant: got %b want 01", bus.req_ready);
      end
      cyc();
      m_rd          = 1'b0;
      bus.req_valid = 2'b00;
      auto_en       = 1'b1;
      mid();
      n_chk++;
      if ({bus.rsp_valid, ram_wr, ram_rd, rd_idx} !== {2'b00, 2'b01, 4'h2}) begin
         n_fail++;
         $display("FAIL rm_reissue: got v=%b wr=%b rd=%b idx=%h want 00 0 1 2",
                  bus.rsp_valid, ram_wr, ram_rd, rd_idx);
      end
      cyc(); cyc();
      mid();
      n_chk++;
      if ({bus.rsp_valid, bus.rsp_err} !== 3'b010) begin
         n_fail++;
         $display("FAIL rm_rsp: got v=%b e=%b want 01 0",
                  bus.rsp_valid, bus.rsp_err);
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_round_robin();
      test_timeout();
      test_spurious_ack();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
